read_port_arbiter: RTL and testbench

- Shares one single-port row-read unit between two requesters. The read unit has a 4-bit row in, a 32-bit data out, and a valid-in/valid-out pulse protocol with variable latency.
- Each requester issues one-cycle request pulses. The arbiter latches them, grants round-robin, and keeps exactly one read in flight.
- It returns data to the owning requester, with a timeout guard against a read unit that never responds.
- Sits between client logic and the read unit, in the same clock domain.

---
 rtl/read_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_read_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency row-read unit between two
// pulse-driven requesters, with exactly one read in flight and a timeout guard.
module read_port_arbiter #(
    parameter  int unsigned TIMEOUT = 32,
    localparam int unsigned ROW_W   = 4,
    localparam int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ROW_W-1:0]  req0_row,
    output logic              req0_busy,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_data,
    output logic              resp0_err,
    input  logic              req1_valid,
    input  logic [ROW_W-1:0]  req1_row,
    output logic              req1_busy,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_data,
    output logic              resp1_err,
    output logic              mem_valid,
    output logic [ROW_W-1:0]  mem_row,
    input  logic              mem_out_valid,
    input  logic [DATA_W-1:0] mem_out
);

    localparam int unsigned     TMR_W    = 8;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state,       w_state_nx;
    logic                r_pend0,       w_pend0_nx;
    logic                r_pend1,       w_pend1_nx;
    logic [ROW_W-1:0]    r_row0,        w_row0_nx;
    logic [ROW_W-1:0]    r_row1,        w_row1_nx;
    logic                r_owner,       w_owner_nx;
    logic                r_last_grant,  w_last_grant_nx;
    logic [TMR_W-1:0]    r_timer,       w_timer_nx;
    logic                r_mem_valid,   w_mem_valid_nx;
    logic [ROW_W-1:0]    r_mem_row,     w_mem_row_nx;
    logic                r_resp0_valid, w_resp0_valid_nx;
    logic [DATA_W-1:0]   r_resp0_data,  w_resp0_data_nx;
    logic                r_resp0_err,   w_resp0_err_nx;
    logic                r_resp1_valid, w_resp1_valid_nx;
    logic [DATA_W-1:0]   r_resp1_data,  w_resp1_data_nx;
    logic                r_resp1_err,   w_resp1_err_nx;

    logic                w_busy0;
    logic                w_busy1;
    logic                w_win;
    logic                w_done;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_rerr;

    // A requester is busy while it has a latched request or owns the read in flight.
    assign w_busy0 = r_pend0 | ((r_state == S_WAIT) & ~r_owner);
    assign w_busy1 = r_pend1 | ((r_state == S_WAIT) &  r_owner);

    always_comb begin
        w_state_nx       = r_state;
        w_pend0_nx       = r_pend0;
        w_pend1_nx       = r_pend1;
        w_row0_nx        = r_row0;
        w_row1_nx        = r_row1;
        w_owner_nx       = r_owner;
        w_last_grant_nx  = r_last_grant;
        w_timer_nx       = r_timer;
        w_mem_valid_nx   = 1'b0;
        w_mem_row_nx     = r_mem_row;
        w_resp0_valid_nx = 1'b0;
        w_resp0_data_nx  = r_resp0_data;
        w_resp0_err_nx   = r_resp0_err;
        w_resp1_valid_nx = 1'b0;
        w_resp1_data_nx  = r_resp1_data;
        w_resp1_err_nx   = r_resp1_err;
        w_win            = 1'b0;
        w_done           = 1'b0;
        w_rdata          = '0;
        w_rerr           = 1'b0;

        if (req0_valid && !w_busy0) begin
            w_pend0_nx = 1'b1;
            w_row0_nx  = req0_row;
        end
        if (req1_valid && !w_busy1) begin
            w_pend1_nx = 1'b1;
            w_row1_nx  = req1_row;
        end

        unique case (r_state)
            S_IDLE: begin
                if (r_pend0 || r_pend1) begin
                    // Lone requester wins; on a tie the one not granted last time wins.
                    w_win           = (r_pend0 && r_pend1) ? ~r_last_grant : r_pend1;
                    w_mem_valid_nx  = 1'b1;
                    w_mem_row_nx    = w_win ? r_row1 : r_row0;
                    w_owner_nx      = w_win;
                    w_last_grant_nx = w_win;
                    w_timer_nx      = '0;
                    w_state_nx      = S_WAIT;
                    if (w_win) begin
                        w_pend1_nx = 1'b0;
                    end else begin
                        w_pend0_nx = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (mem_out_valid) begin
                    w_done  = 1'b1;
                    w_rdata = mem_out;
                end else if (r_timer == TMR_LAST) begin
                    w_done = 1'b1;
                    w_rerr = 1'b1;
                end else begin
                    w_timer_nx = r_timer + TMR_W'(1);
                end

                if (w_done) begin
                    w_state_nx = S_IDLE;
                    if (r_owner) begin
                        w_resp1_valid_nx = 1'b1;
                        w_resp1_data_nx  = w_rdata;
                        w_resp1_err_nx   = w_rerr;
                    end else begin
                        w_resp0_valid_nx = 1'b1;
                        w_resp0_data_nx  = w_rdata;
                        w_resp0_err_nx   = w_rerr;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pend0       <= 1'b0;
            r_pend1       <= 1'b0;
            r_row0        <= '0;
            r_row1        <= '0;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_timer       <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_row     <= '0;
            r_resp0_valid <= 1'b0;
            r_resp0_data  <= '0;
            r_resp0_err   <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp1_data  <= '0;
            r_resp1_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_pend0       <= w_pend0_nx;
            r_pend1       <= w_pend1_nx;
            r_row0        <= w_row0_nx;
            r_row1        <= w_row1_nx;
            r_owner       <= w_owner_nx;
            r_last_grant  <= w_last_grant_nx;
            r_timer       <= w_timer_nx;
            r_mem_valid   <= w_mem_valid_nx;
            r_mem_row     <= w_mem_row_nx;
            r_resp0_valid <= w_resp0_valid_nx;
            r_resp0_data  <= w_resp0_data_nx;
            r_resp0_err   <= w_resp0_err_nx;
            r_resp1_valid <= w_resp1_valid_nx;
            r_resp1_data  <= w_resp1_data_nx;
            r_resp1_err   <= w_resp1_err_nx;
        end
    end

    assign req0_busy   = w_busy0;
    assign req1_busy   = w_busy1;
    assign mem_valid   = r_mem_valid;
    assign mem_row     = r_mem_row;
    assign resp0_valid = r_resp0_valid;
    assign resp0_data  = r_resp0_data;
    assign resp0_err   = r_resp0_err;
    assign resp1_valid = r_resp1_valid;
    assign resp1_data  = r_resp1_data;
    assign resp1_err   = r_resp1_err;

endmodule

// File: tb/tb_read_port_arbiter.sv
// Bench for read_port_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic against a transaction-timing reference model.
module tb_read_port_arbiter;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [3:0]  req0_row;
    logic        req0_busy;
    logic        resp0_valid;
    logic [31:0] resp0_data;
    logic        resp0_err;
    logic        req1_valid;
    logic [3:0]  req1_row;
    logic        req1_busy;
    logic        resp1_valid;
    logic [31:0] resp1_data;
    logic        resp1_err;
    logic        mem_valid;
    logic [3:0]  mem_row;
    logic        mem_out_valid;
    logic [31:0] mem_out;

    read_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req0_row      (req0_row),
        .req0_busy     (req0_busy),
        .resp0_valid   (resp0_valid),
        .resp0_data    (resp0_data),
        .resp0_err     (resp0_err),
        .req1_valid    (req1_valid),
        .req1_row      (req1_row),
        .req1_busy     (req1_busy),
        .resp1_valid   (resp1_valid),
        .resp1_data    (resp1_data),
        .resp1_err     (resp1_err),
        .mem_valid     (mem_valid),
        .mem_row       (mem_row),
        .mem_out_valid (mem_out_valid),
        .mem_out       (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks     = 0;
    int          failures   = 0;
    int          cfg_lat    = 2;     // -1: read unit never answers
    bit          use_tab    = 1'b0;
    int          inject_req = 0;
    int          lat_tab  [16];
    logic [31:0] data_tab [16];

    typedef struct {
        bit          pre;
        bit          v0;
        logic [3:0]  r0;
        bit          v1;
        logic [3:0]  r1;
        logic [74:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [74:0] pk(input logic b0, input logic b1, input logic mv,
                                       input logic [3:0] mrow, input logic r0v,
                                       input logic [31:0] r0d, input logic r0e,
                                       input logic r1v, input logic [31:0] r1d,
                                       input logic r1e);
        return {b0, b1, mv, mrow, r0v, r0e, r1v, r1e, r0d, r1d};
    endfunction

    function automatic logic [74:0] dut_pk();
        return pk(req0_busy, req1_busy, mem_valid, mem_row, resp0_valid, resp0_data,
                  resp0_err, resp1_valid, resp1_data, resp1_err);
    endfunction

    function automatic vec_t mk(input int pre, input int v0, input int r0, input int v1,
                                input int r1, input int b0, input int b1, input int mv,
                                input int mrow, input int r0v, input logic [31:0] r0d,
                                input int r1v, input logic [31:0] r1d);
        vec_t v;
        v.pre = (pre != 0);
        v.v0  = (v0 != 0);
        v.r0  = 4'(r0);
        v.v1  = (v1 != 0);
        v.r1  = 4'(r1);
        v.exp = pk(b0 != 0, b1 != 0, mv != 0, 4'(mrow), r0v != 0, r0d, 1'b0,
                   r1v != 0, r1d, 1'b0);
        return v;
    endfunction

    // Read unit: answers a strobe after a configurable number of extra cycles.
    initial begin : mem_model
        int          cnt;
        int          seen;
        logic [31:0] d;
        cnt = -1;
        seen = 0;
        d = '0;
        mem_out_valid = 1'b0;
        mem_out = '0;
        forever begin
            @(negedge clk);
            mem_out_valid = 1'b0;
            if (!rst_n) begin
                cnt = -1;
            end else if (mem_valid) begin
                cnt = use_tab ? lat_tab[mem_row] : cfg_lat;
                d   = use_tab ? data_tab[mem_row] : 32'hA000_0000 + 32'(mem_row);
            end
            if (inject_req != seen) begin
                seen = inject_req;
                mem_out_valid = 1'b1;
                mem_out = 32'hDEAD_BEEF;
            end else if (cnt == 0) begin
                mem_out_valid = 1'b1;
                mem_out = d;
                cnt = -1;
            end else if (cnt > 0) begin
                cnt--;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        req0_valid = 1'b0;
        req0_row   = 4'd0;
        req1_valid = 1'b0;
        req1_row   = 4'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference: a grant at edge g completes at edge g+min(lat+1, TIMEOUT).
    task automatic run_random(input int ncyc);
        bit          p [2];
        logic [3:0]  prow [2];
        bit          rv [2];
        logic [31:0] rd [2];
        bit          re [2];
        bit          b [2];
        bit          op [2];
        bit          v [2];
        logic [3:0]  r [2];
        bit          infl, fl_err, mv, was_idle;
        logic [3:0]  mrow;
        int          own, last, done_at, fl_row, w, lat, t;

        use_tab = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lat_tab[i]  = int'($urandom_range(5, 0));
            data_tab[i] = $urandom;
        end
        do_reset();
        for (int n = 0; n < 2; n++) begin
            p[n] = 1'b0; prow[n] = 4'd0; rv[n] = 1'b0; rd[n] = '0; re[n] = 1'b0;
        end
        infl = 1'b0; fl_err = 1'b0; mv = 1'b0; mrow = 4'd0;
        own = 0; last = 1; done_at = 0; fl_row = 0; t = 0;

        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            b[0] = p[0] || (infl && own == 0);
            b[1] = p[1] || (infl && own == 1);
            chk($sformatf("rand_c%0d", c), 96'(dut_pk()),
                96'(pk(b[0], b[1], mv, mrow, rv[0], rd[0], re[0], rv[1], rd[1], re[1])));

            for (int n = 0; n < 2; n++) begin
                v[n] = ($urandom_range(2, 0) == 0);
                r[n] = 4'($urandom_range(15, 0));
            end
            req0_valid = v[0]; req0_row = r[0];
            req1_valid = v[1]; req1_row = r[1];

            rv[0] = 1'b0; rv[1] = 1'b0; mv = 1'b0;
            op = p;
            was_idle = !infl;
            if (infl && t == done_at) begin
                rv[own] = 1'b1;
                rd[own] = fl_err ? 32'h0 : data_tab[fl_row];
                re[own] = fl_err;
                infl = 1'b0;
            end
            for (int n = 0; n < 2; n++) begin
                if (v[n] && !b[n]) begin
                    p[n] = 1'b1;
                    prow[n] = r[n];
                end
            end
            if (was_idle && (op[0] || op[1])) begin
                w = (op[0] && op[1]) ? 1 - last : (op[0] ? 0 : 1);
                mv = 1'b1; mrow = prow[w]; p[w] = 1'b0;
                infl = 1'b1; own = w; last = w; fl_row = int'(prow[w]);
                lat = lat_tab[prow[w]];
                fl_err = (lat + 1 > int'(TO));
                done_at = t + (fl_err ? int'(TO) : lat + 1);
            end
            t++;
        end
        clear_inputs();
        repeat (10) @(negedge clk);
    endtask

    initial begin : main
        vec_t vt[$];
        int   own_q[$];
        bit   found;

        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("reset_state", 96'(dut_pk()), 96'(0));

        // Single request, simultaneous requests, dropped pulse (read latency 2).
        vt.push_back(mk(1, 1,3, 0,0, 1,0,0,3'd0, 0,32'h0,          0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 1,0,1,3,    0,32'h0,          0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 1,0,0,3,    0,32'h0,          0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 1,0,0,3,    0,32'h0,          0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 0,0,0,3,    1,32'hA000_0003,  0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 0,0,0,3,    0,32'hA000_0003,  0,32'h0));
        vt.push_back(mk(1, 1,1, 1,8, 1,1,0,0,    0,32'h0,          0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 1,1,1,1,    0,32'h0,          0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 1,1,0,1,    0,32'h0,          0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 1,1,0,1,    0,32'h0,          0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 0,1,0,1,    1,32'hA000_0001,  0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 0,1,1,8,    0,32'hA000_0001,  0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 0,1,0,8,    0,32'hA000_0001,  0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 0,1,0,8,    0,32'hA000_0001,  0,32'h0));
        vt.push_back(mk(0, 0,0, 0,0, 0,0,0,8,    0,32'hA000_0001,  1,32'hA000_0008));
        vt.push_back(mk(0, 0,0, 0,0, 0,0,0,8,    0,32'hA000_0001,  0,32'hA000_0008));
        vt.push_back(mk(0, 1,2, 0,0, 1,0,0,8,    0,32'hA000_0001,  0,32'hA000_0008));
        vt.push_back(mk(0, 1,7, 0,0, 1,0,1,2,    0,32'hA000_0001,  0,32'hA000_0008));
        vt.push_back(mk(0, 1,7, 0,0, 1,0,0,2,    0,32'hA000_0001,  0,32'hA000_0008));
        vt.push_back(mk(0, 0,0, 0,0, 1,0,0,2,    0,32'hA000_0001,  0,32'hA000_0008));
        vt.push_back(mk(0, 0,0, 0,0, 0,0,0,2,    1,32'hA000_0002,  0,32'hA000_0008));
        vt.push_back(mk(0, 0,0, 0,0, 0,0,0,2,    0,32'hA000_0002,  0,32'hA000_0008));
        vt.push_back(mk(0, 0,0, 0,0, 0,0,0,2,    0,32'hA000_0002,  0,32'hA000_0008));

        foreach (vt[i]) begin
            if (vt[i].pre) do_reset();
            @(negedge clk);
            req0_valid = vt[i].v0; req0_row = vt[i].r0;
            req1_valid = vt[i].v1; req1_row = vt[i].r1;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), 96'(dut_pk()), 96'(vt[i].exp));
        end
        @(negedge clk);
        clear_inputs();

        // Round robin: both requesters re-pulse as soon as busy drops.
        do_reset();
        for (int c = 0; c < 300 && own_q.size() < 6; c++) begin
            @(negedge clk);
            if (mem_valid) own_q.push_back(int'(mem_row));
            req0_valid = !req0_busy; req0_row = 4'd0;
            req1_valid = !req1_busy; req1_row = 4'd1;
        end
        clear_inputs();
        chk("rr_grant_count", 96'(own_q.size()), 96'(6));
        foreach (own_q[k]) chk($sformatf("rr_grant%0d", k), 96'(own_q[k]), 96'(k % 2));
        repeat (20) @(negedge clk);

        // Timeout: read unit silent, abort TIMEOUT cycles after the grant.
        cfg_lat = -1;
        @(negedge clk);
        req0_valid = 1'b1; req0_row = 4'd5;
        @(posedge clk);
        #1;
        chk("to_capture_busy", 96'(req0_busy), 96'(1));
        @(negedge clk);
        clear_inputs();
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("to_edge%0d", k), 96'({resp0_valid, req0_busy}), 96'({k == 5, k < 5}));
            if (k == 1) chk("to_grant", 96'({mem_valid, mem_row}), 96'({1'b1, 4'd5}));
            if (k == 5) chk("to_err_resp", 96'({resp0_data, resp0_err}), 96'({32'h0, 1'b1}));
        end
        cfg_lat = 2;
        @(negedge clk);
        req0_valid = 1'b1; req0_row = 4'd6;
        @(negedge clk);
        clear_inputs();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (resp0_valid) found = 1'b1;
        end
        chk("to_recover_seen", 96'(found), 96'(1));
        chk("to_recover_data", 96'({resp0_data, resp0_err}), 96'({32'hA000_0006, 1'b0}));

        // Reset mid-read: outputs clear without a clock edge; late result ignored.
        @(negedge clk);
        req0_valid = 1'b1; req0_row = 4'd9;
        @(negedge clk);
        clear_inputs();
        @(posedge clk);
        #1;
        chk("mr_grant", 96'({mem_valid, mem_row}), 96'({1'b1, 4'd9}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_clear", 96'(dut_pk()), 96'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        inject_req++;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mr_late%0d", k),
                96'({resp0_valid, resp1_valid, mem_valid, req0_busy, req1_busy, resp0_data}),
                96'(0));
        end

        run_random(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
